// File: rtl/bip2_fetch_unit.sv
// BIP-2 instruction fetch and sequencing front end.
// Holds the PC, fetches 16-bit words from instruction memory, presents
// opcode/operand to the control decoder for one issue cycle, and picks the
// next PC from the decoder's Branch/Wrpc response. Stops on HLT or on an
// illegal opcode until reset.
//
// Handshakes:
//   - Memory: imem_rd_o is a one-cycle request. imem_addr_o (= PC) stays stable
//     until imem_valid_i returns. imem_valid_i is accepted only in WAIT, so it
//     has a latency of at least one cycle. Valid in any other state is
//     dropped, and there is no backpressure on the return path.
//   - Decoder: instr_valid_o is a one-cycle pulse. Branch_i and Wrpc_i are
//     sampled only in that same cycle and are ignored at all other times.
module bip2_fetch_unit #(
  parameter int unsigned ADDR_W   = 11,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              start_i,
  output logic              imem_rd_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic [DATA_W-1:0] imem_data_i,
  input  logic              imem_valid_i,
  output logic [4:0]        Opcode_o,
  output logic [ADDR_W-1:0] Operand_o,
  output logic              instr_valid_o,
  input  logic              Branch_i,
  input  logic              Wrpc_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              halted_o,
  output logic              illegal_o,
  output logic [2:0]        dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_ISSUE = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  localparam logic [4:0]        OP_HLT     = 5'b00000;
  localparam logic [4:0]        OP_MAX     = 5'b01110;
  localparam logic [ADDR_W-1:0] RESET_PC_V = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] PC_ONE     = ADDR_W'(1);

  state_t            state_q,   state_d;
  logic [ADDR_W-1:0] pc_q,      pc_d;
  logic [4:0]        opcode_q,  opcode_d;
  logic [ADDR_W-1:0] operand_q, operand_d;
  logic              illegal_q, illegal_d;
  logic              rd_c;
  logic              issue_c;

  // State, PC and latched instruction fields; reset drops any in-flight fetch.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC_V;
      opcode_q  <= 5'd0;
      operand_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      opcode_q  <= opcode_d;
      operand_q <= operand_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state, next-PC and pulse outputs for the fetch/issue sequence.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    opcode_d  = opcode_q;
    operand_d = operand_q;
    illegal_d = illegal_q;
    rd_c      = 1'b0;
    issue_c   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_FETCH;
      end
      S_FETCH: begin
        rd_c    = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_valid_i) begin
          opcode_d  = imem_data_i[DATA_W-1 -: 5];
          operand_d = imem_data_i[ADDR_W-1:0];
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        issue_c = 1'b1;
        if (opcode_q == OP_HLT) begin
          state_d = S_HALT;
        end else if (opcode_q > OP_MAX) begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end else begin
          // Wrpc low leaves the PC alone, so the same word is fetched again.
          if (Wrpc_i) pc_d = Branch_i ? operand_q : pc_q + PC_ONE;
          state_d = S_FETCH;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from registered state.
  always_comb begin
    imem_rd_o     = rd_c;
    imem_addr_o   = pc_q;
    instr_valid_o = issue_c;
    Opcode_o      = opcode_q;
    Operand_o     = operand_q;
    pc_o          = pc_q;
    halted_o      = (state_q == S_HALT);
    illegal_o     = illegal_q;
    dbg_state_o   = state_q;
  end

endmodule

// File: tb/tb_bip2_fetch_unit.sv
// Self-checking bench for bip2_fetch_unit: a memory/decoder driver, a scoreboard
// of fetched words and an architectural PC model.
module tb_bip2_fetch_unit;

  // ---------------- clock / reset ----------------
  logic        clock_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        start_i = 1'b0;
  logic [15:0] imem_data_i = '0;
  logic        imem_valid_i = 1'b0;
  logic        Branch_i = 1'b0;
  logic        Wrpc_i = 1'b0;

  always #5 clock_i = ~clock_i;

  logic        imem_rd_o, instr_valid_o, halted_o, illegal_o;
  logic [10:0] imem_addr_o, Operand_o, pc_o;
  logic [4:0]  Opcode_o;
  logic [2:0]  dbg_state_o;

  // Second instance with the top-of-memory reset PC for the wrap case.
  logic        w_rd, w_iv, w_halted, w_ill;
  logic [10:0] w_addr, w_operand, w_pc;
  logic [4:0]  w_op;
  logic [2:0]  w_dbg;

  bip2_fetch_unit #(.ADDR_W(11), .DATA_W(16), .RESET_PC(0)) u_dut (
    .clock_i(clock_i), .reset_i(reset_i), .start_i(start_i),
    .imem_rd_o(imem_rd_o), .imem_addr_o(imem_addr_o),
    .imem_data_i(imem_data_i), .imem_valid_i(imem_valid_i),
    .Opcode_o(Opcode_o), .Operand_o(Operand_o), .instr_valid_o(instr_valid_o),
    .Branch_i(Branch_i), .Wrpc_i(Wrpc_i), .pc_o(pc_o),
    .halted_o(halted_o), .illegal_o(illegal_o), .dbg_state_o(dbg_state_o)
  );

  bip2_fetch_unit #(.ADDR_W(11), .DATA_W(16), .RESET_PC(2047)) u_dut_wrap (
    .clock_i(clock_i), .reset_i(reset_i), .start_i(start_i),
    .imem_rd_o(w_rd), .imem_addr_o(w_addr),
    .imem_data_i(imem_data_i), .imem_valid_i(imem_valid_i),
    .Opcode_o(w_op), .Operand_o(w_operand), .instr_valid_o(w_iv),
    .Branch_i(Branch_i), .Wrpc_i(Wrpc_i), .pc_o(w_pc),
    .halted_o(w_halted), .illegal_o(w_ill), .dbg_state_o(w_dbg)
  );

  // ---------------- scoreboard / model state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [15:0] mem [2048];
  logic [15:0] exp_q [$];
  int          exp_pc;
  bit          exp_ill;
  logic [15:0] prev_w;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic noise();
    Wrpc_i   = 1'($urandom);
    Branch_i = 1'($urandom);
  endtask

  task automatic do_reset();
    @(negedge clock_i);
    reset_i      = 1'b1;
    start_i      = 1'b0;
    imem_valid_i = 1'b0;
    @(negedge clock_i);
    reset_i = 1'b0;
    check("rst_rd", imem_rd_o, 0);
    check("rst_iv", instr_valid_o, 0);
    check("rst_pc", pc_o, 0);
    check("rst_op", Opcode_o, 0);
    check("rst_operand", Operand_o, 0);
    check("rst_halted", halted_o, 0);
    check("rst_illegal", illegal_o, 0);
    exp_pc  = 0;
    exp_ill = 1'b0;
    prev_w  = '0;
    exp_q.delete();
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the first FETCH.
  task automatic start_run();
    start_i = 1'b1;
    @(negedge clock_i);
    start_i = 1'b0;
  endtask

  // One instruction, entered at the negedge inside FETCH. Returns in the next
  // FETCH, or in HALT with hlt=1.
  task automatic step(input int lat, input bit spur, input bit wrpc, input bit br,
                      output bit hlt);
    logic [15:0] w;
    int          op;
    check("fetch_rd", imem_rd_o, 1);
    check("fetch_addr", imem_addr_o, exp_pc);
    check("fetch_pc", pc_o, exp_pc);
    check("fetch_iv", instr_valid_o, 0);
    exp_q.push_back(mem[exp_pc]);
    imem_valid_i = spur;
    imem_data_i  = 16'($urandom);
    noise();
    for (int k = 1; k <= lat; k++) begin
      @(negedge clock_i);
      check("wait_rd", imem_rd_o, 0);
      check("wait_addr", imem_addr_o, exp_pc);
      check("wait_iv", instr_valid_o, 0);
      check("wait_op_hold", Opcode_o, prev_w[15:11]);
      imem_valid_i = (k == lat);
      imem_data_i  = (k == lat) ? mem[exp_pc] : 16'($urandom);
      noise();
    end
    @(negedge clock_i);
    imem_valid_i = 1'b0;
    w  = exp_q.pop_front();
    op = int'(w[15:11]);
    check("issue_iv", instr_valid_o, 1);
    check("issue_rd", imem_rd_o, 0);
    check("issue_op", Opcode_o, w[15:11]);
    check("issue_operand", Operand_o, w[10:0]);
    Wrpc_i   = wrpc;
    Branch_i = br;
    prev_w   = w;
    hlt      = 1'b0;
    if (op == 0) begin
      hlt = 1'b1;
    end else if (op > 14) begin
      hlt     = 1'b1;
      exp_ill = 1'b1;
    end else if (wrpc) begin
      exp_pc = br ? int'(w[10:0]) : (exp_pc + 1) % 2048;
    end
    @(negedge clock_i);
    noise();
    if (hlt) begin
      check("halt_halted", halted_o, 1);
      check("halt_illegal", illegal_o, exp_ill);
      check("halt_pc", pc_o, exp_pc);
      check("halt_iv", instr_valid_o, 0);
      check("halt_rd", imem_rd_o, 0);
      check("halt_op", Opcode_o, w[15:11]);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit h;
    for (int a = 0; a < 2048; a++) mem[a] = 16'h2000;

    // Load-then-halt program, latency 1.
    mem[0] = 16'h1805;
    mem[1] = 16'h0000;
    do_reset();
    start_run();
    step(1, 1'b0, 1'b1, 1'b0, h);
    check("t1_not_halted", h, 0);
    step(1, 1'b0, 1'b1, 1'b0, h);
    check("t1_pc_final", pc_o, 1);

    // Branch taken and not taken.
    mem[0] = {5'b00111, 11'h040};
    do_reset();
    start_run();
    step(1, 1'b0, 1'b1, 1'b1, h);
    check("br_taken_addr", imem_addr_o, 11'h040);
    do_reset();
    start_run();
    step(1, 1'b0, 1'b1, 1'b0, h);
    check("br_not_taken_addr", imem_addr_o, 11'h001);

    // Wrpc low refetches the same address.
    do_reset();
    start_run();
    step(2, 1'b0, 1'b0, 1'b1, h);
    check("refetch_addr", imem_addr_o, 0);

    // Wrap: both words hold ADD so the shared data bus suits both instances.
    mem[0]    = {5'b00100, 11'h00A};
    mem[2047] = {5'b00100, 11'h00A};
    do_reset();
    check("wrap_rst_pc", w_pc, 2047);
    start_run();
    check("wrap_fetch_addr", w_addr, 2047);
    step(1, 1'b0, 1'b1, 1'b0, h);
    check("wrap_next_rd", w_rd, 1);
    check("wrap_next_addr", w_addr, 0);

    // Latency 4 with a spurious valid during FETCH.
    mem[0] = {5'b00101, 11'h3C1};
    do_reset();
    start_run();
    step(4, 1'b1, 1'b1, 1'b0, h);
    check("lat4_next_addr", imem_addr_o, 1);

    // Illegal opcode, then start pulses in HALT.
    mem[0] = {5'b10101, 11'h123};
    do_reset();
    start_run();
    step(1, 1'b0, 1'b1, 1'b1, h);
    check("ill_illegal", illegal_o, 1);
    for (int k = 0; k < 4; k++) begin
      start_i = 1'($urandom);
      if (k == 0) start_i = 1'b1;
      @(negedge clock_i);
      check("ill_stay_halted", halted_o, 1);
      check("ill_no_rd", imem_rd_o, 0);
      check("ill_pc", pc_o, 0);
    end
    start_i = 1'b0;

    // Reset while WAIT, memory returns valid the cycle after.
    mem[0] = 16'h1805;
    do_reset();
    start_run();
    imem_valid_i = 1'b0;
    @(negedge clock_i);
    reset_i = 1'b1;
    @(negedge clock_i);
    reset_i      = 1'b0;
    imem_valid_i = 1'b1;
    imem_data_i  = 16'h1805;
    @(negedge clock_i);
    imem_valid_i = 1'b0;
    check("rw_iv", instr_valid_o, 0);
    check("rw_rd", imem_rd_o, 0);
    check("rw_pc", pc_o, 0);
    check("rw_illegal", illegal_o, 0);
    check("rw_halted", halted_o, 0);
    check("rw_op", Opcode_o, 0);
    @(negedge clock_i);
    check("rw_iv2", instr_valid_o, 0);
    check("rw_rd2", imem_rd_o, 0);

    // Random programs.
    for (int p = 0; p < 6; p++) begin
      for (int a = 0; a < 2048; a++) begin
        int r;
        r = int'($urandom_range(0, 99));
        if (r < 3)      mem[a] = {5'd0, 11'($urandom)};
        else if (r < 6) mem[a] = {5'($urandom_range(15, 31)), 11'($urandom)};
        else            mem[a] = {5'($urandom_range(1, 14)), 11'($urandom)};
      end
      do_reset();
      start_run();
      h = 1'b0;
      for (int i = 0; i < 30 && !h; i++) begin
        step(int'($urandom_range(1, 5)), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 4) != 0), 1'($urandom), h);
      end
    end

    // ---------------- final report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
